// File: rtl/turn_lights_pkg.sv
// turn_lights_pkg: mode encoding, lamp ordering and animation tables shared by the tail-light blocks
package turn_lights_pkg;
  typedef enum logic [1:0] {MODE_IDLE, MODE_HAZ, MODE_LEFT, MODE_RIGHT} mode_e;
  localparam int LEFT_INNER_BIT  = 0;
  localparam int RIGHT_INNER_BIT = 2;
  localparam logic [2:0] LEFT_SEQ  [0:3] = '{3'b000, 3'b001, 3'b011, 3'b111};
  localparam logic [2:0] RIGHT_SEQ [0:3] = '{3'b000, 3'b100, 3'b110, 3'b111};
  localparam logic [5:0] HAZ_ON = 6'b111111;
endpackage

// File: rtl/turn_pattern_gen_if.sv
// turn_pattern_gen_if: select inputs from the controller and the lamp patterns fed back to it
interface turn_pattern_gen_if;
  logic       L, H, R;
  logic [2:0] left_out, right_out;
  logic [5:0] haz_out;
  logic       tick;
  modport master (output L, H, R, input left_out, right_out, haz_out, tick);
  modport slave  (input L, H, R, output left_out, right_out, haz_out, tick);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to the animation step rate, restartable via clr
module tick_prescaler #(
  parameter int PRESCALE = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic step
);
  localparam int CNT_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
  logic [CNT_W-1:0] presc_q;
  logic             tick_q;
  // step is the combinational terminal count so the phase advances on the same edge tick rises
  assign step = en && !clr && presc_q == LAST;
  assign tick = tick_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else if (clr || !en) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= step ? '0 : presc_q + CNT_W'(1);
      tick_q  <= step;
    end
  end
endmodule

// File: rtl/turn_pattern_gen.sv
// turn_pattern_gen: priority-encodes the controller selects and animates the matching lamp pattern
module turn_pattern_gen #(
  parameter int PRESCALE = 12500000
) (
  input logic clk,
  input logic rst,
  turn_pattern_gen_if.slave bus
);
  import turn_lights_pkg::*;
  mode_e      mode_q, mode_d;
  logic [1:0] phase_q, phase_d;
  logic       chg, step;
  always_comb mode_d = bus.H ? MODE_HAZ : bus.L ? MODE_LEFT : bus.R ? MODE_RIGHT : MODE_IDLE;
  assign chg = mode_d != mode_q;
  // hazard only ever toggles phase bit0
  assign phase_d = chg ? 2'd0 : !step ? phase_q :
                   mode_q == MODE_HAZ ? {1'b0, ~phase_q[0]} : phase_q + 2'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_IDLE;
      phase_q <= 2'd0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (chg),
    .en   (mode_q != MODE_IDLE),
    .tick (bus.tick),
    .step (step)
  );
  assign bus.left_out  = mode_q == MODE_LEFT  ? LEFT_SEQ[phase_q]  : 3'b000;
  assign bus.right_out = mode_q == MODE_RIGHT ? RIGHT_SEQ[phase_q] : 3'b000;
  assign bus.haz_out   = mode_q == MODE_HAZ && phase_q[0] ? HAZ_ON : 6'b000000;
endmodule
